// File: rtl/rtc_access_scheduler.sv
// RTC access scheduler: sole owner of the RTC bus-cycle engine. Runs periodic
// read sweeps of the time/date registers into the RAM mirror and slots user
// writes between sweep items. Every engine transaction is bounded by a timeout.
module rtc_access_scheduler #(
  parameter logic [7:0] BASE_ADDR = 8'h21,
  parameter int         N_REGS    = 6,
  parameter int         TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       wr_req,
  input  logic [2:0] wr_sel,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       eng_start,
  output logic       eng_w_r,
  output logic [7:0] eng_addr,
  output logic [7:0] eng_wdata,
  input  logic [7:0] eng_rdata,
  input  logic       eng_done,
  output logic       ram_we,
  output logic [2:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       busy,
  output logic       sweep_done,
  output logic       timeout_err
);

  localparam int           TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0]   LAST_IDX = 3'(N_REGS - 1);
  localparam logic [3:0]   NREG4    = 4'(N_REGS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_STORE = 3'd3,
    S_ACK   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          sweep_pend_q, sweep_pend_d;
  logic [2:0]    rd_idx_q, rd_idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          op_wr_q, op_wr_d;     // latched operation: 1 = write
  logic [2:0]    idx_q, idx_d;         // latched register index
  logic [7:0]    wdata_q, wdata_d;     // latched write data (0 for reads)
  logic [7:0]    rdata_q, rdata_d;     // captured read data for STORE
  logic          sweep_end;
  logic          tmo_fire;
  logic          in_txn;

  // State and operand registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sweep_pend_q <= 1'b0;
      rd_idx_q     <= '0;
      tmo_q        <= '0;
      op_wr_q      <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      sweep_pend_q <= sweep_pend_d;
      rd_idx_q     <= rd_idx_d;
      tmo_q        <= tmo_d;
      op_wr_q      <= op_wr_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Arbitration, transaction sequencing and sweep index bookkeeping.
  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    tmo_d     = tmo_q;
    op_wr_d   = op_wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    sweep_end = 1'b0;
    tmo_fire  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wr_req) begin
          op_wr_d = 1'b1;
          idx_d   = wr_sel;
          wdata_d = wr_data;
          // Out-of-range index is acknowledged without touching the engine.
          state_d = ({1'b0, wr_sel} >= NREG4) ? S_ACK : S_START;
        end else if (sweep_pend_q) begin
          op_wr_d = 1'b0;
          idx_d   = rd_idx_q;
          wdata_d = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // A completion in the terminal-count cycle still counts as success.
        if (eng_done) begin
          if (op_wr_q) begin
            state_d = S_ACK;
          end else begin
            rdata_d = eng_rdata;
            state_d = S_STORE;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_fire = 1'b1;
          if (op_wr_q) begin
            state_d = S_ACK;
          end else begin
            // Aborted read still moves the sweep on; the slot keeps old data.
            if (rd_idx_q == LAST_IDX) begin
              sweep_end = 1'b1;
              rd_idx_d  = '0;
            end else begin
              rd_idx_d = rd_idx_q + 1'b1;
            end
            state_d = S_IDLE;
          end
        end
      end
      S_STORE: begin
        if (rd_idx_q == LAST_IDX) begin
          sweep_end = 1'b1;
          rd_idx_d  = '0;
        end else begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
        state_d = S_IDLE;
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A tick landing on the last item re-arms a fresh sweep from index 0.
  always_comb begin
    sweep_pend_d = refresh_tick | (sweep_pend_q & ~sweep_end);
  end

  // Output decode: engine operands are only driven while a transaction is open.
  always_comb begin
    in_txn      = (state_q == S_START) || (state_q == S_WAIT);
    busy        = (state_q != S_IDLE);
    eng_start   = (state_q == S_START);
    eng_w_r     = in_txn & op_wr_q;
    eng_addr    = in_txn ? (BASE_ADDR + {5'd0, idx_q}) : 8'd0;
    eng_wdata   = in_txn ? wdata_q : 8'd0;
    ram_we      = (state_q == S_STORE);
    ram_addr    = (state_q == S_STORE) ? idx_q : 3'd0;
    ram_wdata   = (state_q == S_STORE) ? rdata_q : 8'd0;
    wr_ack      = (state_q == S_ACK);
    sweep_done  = sweep_end;
    timeout_err = tmo_fire;
  end

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Scoreboard bench for rtc_access_scheduler: stimulus pushes the expected
// output event sequence, a negedge monitor pops and compares.
module tb_rtc_access_scheduler;

  localparam logic [7:0] BASE = 8'h21;
  localparam int NR  = 6;
  localparam int TMO = 64;

  localparam int K_ST  = 0;
  localparam int K_RAM = 1;
  localparam int K_SDN = 2;
  localparam int K_ACK = 3;
  localparam int K_TMO = 4;

  typedef struct {
    int         kind;
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    int         dly;   // cycles after most recent eng_start, -1 = unchecked
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       refresh_tick, wr_req;
  logic [2:0] wr_sel;
  logic [7:0] wr_data;
  logic       wr_ack, eng_start, eng_w_r;
  logic [7:0] eng_addr, eng_wdata, eng_rdata;
  logic       eng_done, ram_we;
  logic [2:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       busy, sweep_done, timeout_err;

  ev_t sbq[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  last_start = 0;
  int  starts_seen = 0;
  int  eng_lat = 34;
  int  eng_salt = 0;
  int  hang_idx = -1;

  rtc_access_scheduler dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick),
    .wr_req(wr_req), .wr_sel(wr_sel), .wr_data(wr_data), .wr_ack(wr_ack),
    .eng_start(eng_start), .eng_w_r(eng_w_r), .eng_addr(eng_addr),
    .eng_wdata(eng_wdata), .eng_rdata(eng_rdata), .eng_done(eng_done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .busy(busy), .sweep_done(sweep_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  function automatic string kname(input int k);
    case (k)
      K_ST: return "start";
      K_RAM: return "ram_we";
      K_SDN: return "sweep_done";
      K_ACK: return "wr_ack";
      default: return "timeout_err";
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // Monitor side: pop one expected event and compare against what the DUT shows.
  task automatic ev_chk(input int k, input logic w, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL unexpected %s w=%0b a=%h d=%h at cyc %0d, required no event", kname(k), w, a, d, cyc);
      return;
    end
    e = sbq.pop_front();
    if (e.kind != k || e.w != w || e.a != a || e.d != d) begin
      bad++;
      $display("FAIL event at cyc %0d: got %s w=%0b a=%h d=%h, required %s w=%0b a=%h d=%h",
               cyc, kname(k), w, a, d, kname(e.kind), e.w, e.a, e.d);
    end else if (e.dly >= 0 && (cyc - last_start) != e.dly) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles after start, required %0d", kname(k), cyc - last_start, e.dly);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (timeout_err) ev_chk(K_TMO, 1'b0, 8'd0, 8'd0);
      if (ram_we)      ev_chk(K_RAM, 1'b0, {5'd0, ram_addr}, ram_wdata);
      if (sweep_done)  ev_chk(K_SDN, 1'b0, 8'd0, 8'd0);
      if (wr_ack)      ev_chk(K_ACK, 1'b0, 8'd0, 8'd0);
      if (eng_start) begin
        ev_chk(K_ST, eng_w_r, eng_addr, eng_wdata);
        last_start = cyc;
        starts_seen++;
      end
    end
  end

  // Engine model: done eng_lat cycles after start, rdata = (0x10+idx)^salt.
  initial begin
    logic [7:0] a;
    eng_done = 1'b0;
    eng_rdata = 8'd0;
    forever begin
      @(negedge clk);
      eng_rdata = 8'($urandom);
      if (reset && eng_start) begin
        a = eng_addr;
        if (!(!eng_w_r && hang_idx >= 0 && a == BASE + 8'(hang_idx))) begin
          repeat (eng_lat) @(posedge clk);
          #1;
          eng_done = 1'b1;
          eng_rdata = (a - BASE + 8'h10) ^ 8'(eng_salt);
          @(posedge clk);
          #1;
          eng_done = 1'b0;
        end
      end
    end
  end

  function automatic ev_t mk(input int k, input logic w, input logic [7:0] a, input logic [7:0] d, input int dly);
    ev_t e;
    e.kind = k; e.w = w; e.a = a; e.d = d; e.dly = dly;
    return e;
  endfunction

  // Reference: a sweep is N reads in index order; a write raised during item
  // wr_after is served right after that item; a hung read times out.
  task automatic push_write(input int sel, input logic [7:0] data);
    if (sel < NR) begin
      sbq.push_back(mk(K_ST, 1'b1, BASE + 8'(sel), data, -1));
      sbq.push_back(mk(K_ACK, 1'b0, 8'd0, 8'd0, eng_lat + 1));
    end else begin
      sbq.push_back(mk(K_ACK, 1'b0, 8'd0, 8'd0, -1));
    end
  endtask

  task automatic push_sweep(input int hang, input int wr_after, input int sel, input logic [7:0] data);
    for (int i = 0; i < NR; i++) begin
      sbq.push_back(mk(K_ST, 1'b0, BASE + 8'(i), 8'd0, -1));
      if (i == hang) sbq.push_back(mk(K_TMO, 1'b0, 8'd0, 8'd0, TMO));
      else sbq.push_back(mk(K_RAM, 1'b0, 8'(i), (8'h10 + 8'(i)) ^ 8'(eng_salt), eng_lat + 1));
      if (i == NR - 1) sbq.push_back(mk(K_SDN, 1'b0, 8'd0, 8'd0, -1));
      if (i == wr_after) push_write(sel, data);
    end
  endtask

  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    while ((sbq.size() != 0 || busy) && c < 3000) begin
      @(negedge clk); #1;
      c++;
    end
    chk({nm, " drained"}, int'(c < 3000), 1);
    chk({nm, " busy low"}, int'(busy), 0);
  endtask

  task automatic wait_starts(input int target, output bit ok);
    int c;
    c = 0;
    while (starts_seen < target && c < 500) begin
      @(negedge clk); #1;
      c++;
    end
    ok = (starts_seen >= target);
    chk("start wait", int'(ok), 1);
  endtask

  task automatic run_sweep(input string nm, input int lat, input int salt, input int hang,
                           input int wr_after, input int sel, input logic [7:0] data);
    int base;
    bit ok;
    eng_lat = lat; eng_salt = salt; hang_idx = hang;
    push_sweep(hang, wr_after, sel, data);
    base = starts_seen;
    @(negedge clk); #1; refresh_tick = 1'b1;
    @(negedge clk); #1; refresh_tick = 1'b0;
    if (wr_after >= 0) begin
      wait_starts(base + wr_after + 1, ok);
      wr_sel = 3'(sel); wr_data = data; wr_req = 1'b1;
      for (int c = 0; c < 500 && !wr_ack; c++) begin @(negedge clk); #1; end
      chk({nm, " ack seen"}, int'(wr_ack), 1);
      wr_req = 1'b0;
    end
    wait_idle(nm);
    hang_idx = -1;
  endtask

  task automatic idle_write(input int sel, input logic [7:0] data);
    int n;
    push_write(sel, data);
    @(negedge clk); #1;
    n = cyc;
    wr_sel = 3'(sel); wr_data = data; wr_req = 1'b1;
    if (sel < NR) begin
      for (int c = 0; c < 10 && !eng_start; c++) begin @(negedge clk); #1; end
      chk("write start latency", cyc - n, 1);
    end
    for (int c = 0; c < 200 && !wr_ack; c++) begin @(negedge clk); #1; end
    if (sel >= NR) chk("invalid ack within 2", int'((cyc - n) <= 2 && wr_ack), 1);
    else chk("write ack latency", cyc - n, eng_lat + 2);
    wr_req = 1'b0;
    wait_idle("idle write");
  endtask

  initial begin
    int d, st0;
    reset = 1'b0; refresh_tick = 1'b0; wr_req = 1'b0; wr_sel = 3'd0; wr_data = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset eng_start", int'(eng_start), 0);
    chk("reset eng_addr", int'(eng_addr), 0);
    chk("reset outputs", int'({wr_ack, eng_w_r, eng_wdata, ram_we, ram_addr, ram_wdata, sweep_done, timeout_err}), 0);
    @(posedge clk); #2; reset = 1'b1;
    repeat (3) @(negedge clk);

    run_sweep("sweep", 34, 0, -1, -1, 0, 8'd0);
    run_sweep("write prio", 34, 0, -1, 1, 2, 8'h45);
    eng_lat = 34;
    idle_write(7, 8'h99);
    idle_write(4, 8'h3c);
    run_sweep("timeout", 34, 0, 3, -1, 0, 8'd0);
    run_sweep("timeout last", 20, 8'h5a, 5, -1, 0, 8'd0);

    // Tick in the sweep_done cycle: second sweep starts two cycles later.
    eng_lat = 10; eng_salt = 8'h33;
    push_sweep(-1, -1, 0, 8'd0);
    push_sweep(-1, -1, 0, 8'd0);
    @(negedge clk); #1; refresh_tick = 1'b1;
    @(negedge clk); #1; refresh_tick = 1'b0;
    for (int c = 0; c < 1000 && !sweep_done; c++) begin @(negedge clk); #1; end
    chk("first sweep_done", int'(sweep_done), 1);
    refresh_tick = 1'b1;
    d = cyc;
    @(posedge clk); #1; refresh_tick = 1'b0;
    for (int c = 0; c < 10 && !eng_start; c++) begin @(negedge clk); #1; end
    chk("resweep gap", cyc - d, 2);
    chk("resweep addr", int'(eng_addr), int'(BASE));
    wait_idle("resweep");

    for (int r = 0; r < 6; r++) begin
      int wa, h;
      wa = int'($urandom_range(0, 6)) - 1;
      h  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 5)) : -1;
      run_sweep("random", int'($urandom_range(2, 40)), int'($urandom_range(0, 255)), h, wa,
                int'($urandom_range(0, 7)), 8'($urandom));
    end

    // Reset in WAIT: outputs clear at once and nothing restarts afterwards.
    eng_lat = 40;
    sbq.push_back(mk(K_ST, 1'b1, BASE + 8'd1, 8'h77, -1));
    @(negedge clk); #1;
    wr_sel = 3'd1; wr_data = 8'h77; wr_req = 1'b1;
    for (int c = 0; c < 10 && !eng_start; c++) begin @(negedge clk); #1; end
    wr_req = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk); #2;
    chk("pre-reset busy", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("async busy", int'(busy), 0);
    chk("async eng_addr", int'(eng_addr), 0);
    chk("async eng_w_r/wdata", int'({eng_w_r, eng_wdata}), 0);
    sbq.delete();
    @(negedge clk); #1; reset = 1'b1;
    st0 = starts_seen;
    repeat (100) @(negedge clk);
    #1;
    chk("no restart", starts_seen - st0, 0);
    chk("idle after reset", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
